blk_arbiter: RTL
================

# blk_arbiter

Read side of the channel block protocol. Round-robins across NCH channel output FIFOs using the per-channel give/have handshake and pulls complete blocks one at a time. Each block starts with a control word whose format is 1 CCCCCC LLLLLLLLL. The block is forwarded, unbroken, to a single 16-bit downstream stream with start/end markers. It sits between the channel processors and the GTP/readout packer, all on the 125 MHz clk.

## Interface

Parameters:
- NCH, 16: number of channels polled
- CHW, 4: pointer width, must satisfy 2**CHW >= NCH
- TOUT, 255: maximum consecutive stall cycles inside a block before abort (8-bit compare)

Ports:
- clk  in  1  125 MHz system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- give  out  NCH  one-hot read request to the channels; combinational
- have  in  NCH  per-channel acknowledge; a word is consumed in any cycle where give[k] & have[k]
- din  in  16*NCH  per-channel data; channel k occupies bits [16k+15:16k]; valid in the same cycle as have[k]
- oready  in  1  downstream can accept a word in the next cycle
- odata  out  16  forwarded word, registered
- ovalid  out  1  odata valid, one-cycle qualifier
- osob  out  1  with ovalid: word is a control word
- oeob  out  1  with ovalid: last word of the block
- oabort  out  1  one-cycle pulse: the current block was truncated
- blkcnt  out  16  count of completed blocks; wraps
- errcnt  out  8  protocol error count; saturates at 255

## Operation

- Reset: give=0, odata=0, ovalid=osob=oeob=oabort=0, blkcnt=0, errcnt=0, ptr=0, state=SCAN.
- give[k] = (ptr==k) & oready & (state is SCAN or DATA). Never more than one bit is set.
- SCAN state:
  - have[ptr]=0: ptr advances to ptr+1, or to 0 if ptr==NCH-1. One probe per cycle.
  - have[ptr]=1 and din bit15=1: control word. Forward it with osob=1. Load cnt = L (bits [8:0]).
    - L=0: also assert oeob, blkcnt++, ptr advances, stay in SCAN.
    - Otherwise: go to DATA.
  - have[ptr]=1 and din bit15=0: desync. Word is discarded, errcnt++, ptr is held so the channel drains to the next control word.
- DATA state:
  - A consumed word with bit15=0 is forwarded. cnt decrements.
  - When cnt==1 is consumed: oeob=1, blkcnt++, ptr advances, go to SCAN.
  - A consumed word with bit15=1 is an error. Discard it, errcnt++, oabort, return to SCAN with ptr held.
  - Stall counter: clears on every consumed word. Increments on each cycle with oready & ~have[ptr].
    - On reaching TOUT: oabort, errcnt++, ptr advances, go to SCAN.
  - oready=0 freezes the stall counter and cnt.
- Downstream sees every block contiguous. Once a control word is emitted, no other channel's words appear until oeob or oabort.

## Timing

- Read latency is zero: din is sampled in the cycle give&have are both high. odata/ovalid/osob/oeob appear on the next rising edge.
- Full throughput is one word per clk while oready=1 and have stays high.
- Block of length L from an idle arbiter on ptr: L+1 cycles of transfer. If the block is not on ptr, add up to NCH-1 probe cycles first.
- oready contract: oready high in cycle t guarantees the sink accepts the ovalid word at t+1. Dropping oready removes give combinationally in the same cycle.
- Status outputs update on the same edge as the related ovalid/oabort: blkcnt with the oeob word, oabort one cycle, errcnt on the edge after the offending cycle.
- rst_n assertion mid-block drops give immediately (combinational from state). The partial block is lost with no oeob.
- Counter wrap: blkcnt rolls 0xFFFF→0x0000. errcnt holds at 0xFF.

## Configuration

- BLK_ARB_CHKNUM_EN defined: a control word whose channel field (bits [14:9]) is not equal to ptr is treated as a bad block.
  - The control word and the L following words are still consumed so the channel stays aligned, but none are forwarded (ovalid=0).
  - errcnt++ once for the block; blkcnt is not incremented.
- Undefined: the channel field is not checked. Any control word is forwarded.

## Test plan

- Single block, channel 3: control word 0x8603 (ch 3, L=3) plus 3 data words, oready=1 → 4 ovalid cycles, osob on 0x8603, oeob on the 3rd data word, blkcnt=1, give[3] low after the last word.
- Channels 0 and 5 both hold blocks of L=2 → channel 0 block fully emitted, then channel 5; no interleaving; ptr probes 1..4 one cycle each in between.
- oready toggled 1/0 every cycle during an L=10 block → all 11 words delivered in order, no duplicates or loss, and no give while oready=0.
- Channel stops asserting have after 2 of 5 data words, TOUT=255 → oabort 255 cycles after the last word, errcnt=1, arbiter resumes scanning at ptr+1.
- Leading word 0x0123 (bit15=0) before a valid control word → word discarded, errcnt=1, the following block forwarded normally.
- With BLK_ARB_CHKNUM_EN, channel 2 presents control word field ch=7 with L=4 → 5 words consumed, ovalid never asserted, errcnt=1, blkcnt unchanged.

Source files
------------

// File: rtl/blk_arbiter.sv
// blk_arbiter: round-robin block reader over NCH channel FIFOs; define BLK_ARB_CHKNUM_EN to drop blocks whose channel field mismatches ptr
module blk_arbiter #(
  parameter int NCH  = 16,
  parameter int CHW  = 4,
  parameter int TOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [NCH-1:0]    give,
  input  logic [NCH-1:0]    have,
  input  logic [16*NCH-1:0] din,
  input  logic              oready,
  output logic [15:0]       odata,
  output logic              ovalid,
  output logic              osob,
  output logic              oeob,
  output logic              oabort,
  output logic [15:0]       blkcnt,
  output logic [7:0]        errcnt
);
  typedef enum logic {SCAN, DATA} state_t;
  state_t state, state_nx;
  logic [CHW-1:0] ptr, ptr_nx, ptr_inc;
  logic [8:0] cnt, cnt_nx;
  logic [7:0] stall, stall_nx;
  logic drop, drop_nx, bad, hv, fwd, sob, eob, abort, err, done;
  logic [15:0] w;
  assign w = din[16*ptr +: 16];
  assign hv = have[ptr];
  assign ptr_inc = (ptr == CHW'(NCH-1)) ? '0 : ptr + 1'b1;
  assign give = (rst_n && oready) ? NCH'(1) << ptr : '0;
`ifdef BLK_ARB_CHKNUM_EN
  assign bad = w[14:9] != 6'(ptr);
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    cnt_nx = cnt;
    stall_nx = stall;
    drop_nx = drop;
    fwd = 1'b0;
    sob = 1'b0;
    eob = 1'b0;
    abort = 1'b0;
    err = 1'b0;
    done = 1'b0;
    if (oready) begin
      if (state == SCAN) begin
        if (!hv) ptr_nx = ptr_inc;
        else if (!w[15]) err = 1'b1;
        else begin
          fwd = ~bad;
          sob = ~bad;
          err = bad;
          cnt_nx = w[8:0];
          stall_nx = '0;
          drop_nx = bad;
          if (w[8:0] == 9'd0) begin
            eob = ~bad;
            done = ~bad;
            ptr_nx = ptr_inc;
          end else state_nx = DATA;
        end
      end else if (hv) begin
        stall_nx = '0;
        if (w[15]) begin
          err = 1'b1;
          abort = 1'b1;
          state_nx = SCAN;
        end else begin
          fwd = ~drop;
          cnt_nx = cnt - 1'b1;
          if (cnt == 9'd1) begin
            eob = ~drop;
            done = ~drop;
            ptr_nx = ptr_inc;
            state_nx = SCAN;
          end
        end
      end else begin
        stall_nx = stall + 1'b1;
        if (stall == 8'(TOUT-1)) begin
          abort = 1'b1;
          err = 1'b1;
          ptr_nx = ptr_inc;
          state_nx = SCAN;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      ptr <= '0;
      cnt <= '0;
      stall <= '0;
      drop <= 1'b0;
      odata <= '0;
      ovalid <= 1'b0;
      osob <= 1'b0;
      oeob <= 1'b0;
      oabort <= 1'b0;
      blkcnt <= '0;
      errcnt <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
      stall <= stall_nx;
      drop <= drop_nx;
      if (fwd) odata <= w;
      ovalid <= fwd;
      osob <= sob;
      oeob <= eob;
      oabort <= abort;
      blkcnt <= blkcnt + 16'(done);
      errcnt <= (err && errcnt != 8'hFF) ? errcnt + 8'd1 : errcnt;
    end
  end
endmodule
